multdiv_unit: RTL

MULTDIV_UNIT -- requirements
Module: multdiv_unit

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/div_step.sv | 25 ++
 rtl/multdiv_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, iteration count and state encoding for the multiply/divide unit.
package cpu_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITERS = 32;
    localparam int unsigned CNT_W = 6;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MULT = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

    // Magnitude of a two's complement value; the most negative value maps onto itself as unsigned.
    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract division iteration on unsigned magnitudes.
module div_step
    import cpu_pkg::*;
#(
    parameter int unsigned W = WIDTH
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out_c,
    output logic         q_bit_c
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // Shift the next dividend bit in and keep the difference only when it does not borrow.
    always_comb begin
        shifted   = {rem_in, bit_in};
        diff      = shifted - {1'b0, divisor};
        q_bit_c   = ~diff[W];
        rem_out_c = q_bit_c ? diff[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit: 32 magnitude iterations, one sign-fix cycle, one done cycle.
module multdiv_unit #(
    parameter int unsigned WIDTH = cpu_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    import cpu_pkg::*;

    localparam int unsigned PW = 2 * WIDTH;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             neg_q, neg_d;
    logic             bzero_q, bzero_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    logic             start_c;
    logic             last_iter_c;
    logic [WIDTH:0]   mult_sum_c;
    logic [PW-1:0]    mult_next_c;
    logic [PW-1:0]    prod_signed_c;
    logic [WIDTH-1:0] quot_signed_c;
    logic [WIDTH-1:0] div_rem_c;
    logic             div_q_c;

    assign start_c     = ctrl_MULT | ctrl_DIV;
    assign last_iter_c = (cnt_q == LAST_ITER);

    // acc_q holds {remainder, dividend/quotient} while dividing.
    div_step #(
        .W (WIDTH)
    ) u_div_step (
        .rem_in    (acc_q[PW-1:WIDTH]),
        .bit_in    (acc_q[WIDTH-1]),
        .divisor   (opb_q),
        .rem_out_c (div_rem_c),
        .q_bit_c   (div_q_c)
    );

    // Multiply step and sign application; acc_q holds {partial product, remaining multiplier}.
    always_comb begin
        mult_sum_c    = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mult_next_c   = {mult_sum_c, acc_q[WIDTH-1:1]};
        prod_signed_c = neg_q ? PW'(-acc_q) : acc_q;
        quot_signed_c = neg_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; any start restarts, multiply wins a tie.
    always_comb begin
        state_d = state_q;
        if (start_c) begin
            state_d = ctrl_MULT ? ST_MULT : ST_DIV;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_MULT: state_d = last_iter_c ? ST_FIX : ST_MULT;
                ST_DIV:  state_d = last_iter_c ? ST_FIX : ST_DIV;
                ST_FIX:  state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and output next values.
    always_comb begin
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        bzero_d  = bzero_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        busy_d   = (state_d == ST_MULT) || (state_d == ST_DIV) || (state_d == ST_FIX);
        if (start_c) begin
            op_d    = ctrl_MULT ? OP_MULT : OP_DIV;
            cnt_d   = '0;
            acc_d   = {{WIDTH{1'b0}}, abs_mag(data_operandA)};
            opb_d   = abs_mag(data_operandB);
            neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            bzero_d = (data_operandB == '0);
        end else begin
            case (state_q)
                ST_MULT: begin
                    acc_d = mult_next_c;
                    cnt_d = last_iter_c ? '0 : cnt_q + CNT_W'(1);
                end
                ST_DIV: begin
                    acc_d = {div_rem_c, acc_q[WIDTH-2:0], div_q_c};
                    cnt_d = last_iter_c ? '0 : cnt_q + CNT_W'(1);
                end
                ST_FIX: begin
                    rdy_d = 1'b1;
                    if (op_q == OP_MULT) begin
                        result_d = prod_signed_c[WIDTH-1:0];
                        exc_d    = (prod_signed_c[PW-1:WIDTH] != {WIDTH{prod_signed_c[WIDTH-1]}});
                    end else if (bzero_q) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = quot_signed_c;
                        exc_d    = ~neg_q & acc_q[WIDTH-1];
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= OP_MULT;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            bzero_q  <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            bzero_q  <= bzero_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule
